// File: rtl/axi3_sram_responder.sv
// AXI3 slave serving FIXED/INCR/WRAP bursts (up to 16 beats) from a word-wide SRAM model.
// One transaction in flight; simultaneous read/write requests are granted alternately.
module axi3_sram_responder #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned ID_W   = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] s_arid,
  input  logic [31:0]     s_araddr,
  input  logic [3:0]      s_arlen,
  input  logic [2:0]      s_arsize,
  input  logic [1:0]      s_arburst,
  input  logic [1:0]      s_arlock,
  input  logic [3:0]      s_arcache,
  input  logic [2:0]      s_arprot,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [ID_W-1:0] s_rid,
  output logic [31:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rlast,
  output logic            s_rvalid,
  input  logic            s_rready,
  input  logic [ID_W-1:0] s_awid,
  input  logic [31:0]     s_awaddr,
  input  logic [3:0]      s_awlen,
  input  logic [2:0]      s_awsize,
  input  logic [1:0]      s_awburst,
  input  logic [1:0]      s_awlock,
  input  logic [3:0]      s_awcache,
  input  logic [2:0]      s_awprot,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [ID_W-1:0] s_wid,
  input  logic [31:0]     s_wdata,
  input  logic [3:0]      s_wstrb,
  input  logic            s_wlast,
  input  logic            s_wvalid,
  output logic            s_wready,
  output logic [ID_W-1:0] s_bid,
  output logic [1:0]      s_bresp,
  output logic            s_bvalid,
  input  logic            s_bready
);
  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, RBURST, WDATA, WRESP} state_e;

  state_e          state_q, state_d;
  logic            grant_wr_q, grant_wr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            err_any_q, err_any_d;
  logic            rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d, bresp_q, bresp_d;
  logic [ID_W-1:0] rid_q, rid_d, bid_q, bid_d;
  logic            bvalid_q, bvalid_d;
  logic [31:0]     mem_q [DEPTH];
  logic            mem_we;
  logic [31:0]     nxt_addr, rd_addr, rd_word;
  logic [2:0]      rd_size;
  logic            rd_err;

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [3:0] ln, input logic [1:0] bt);
    logic [31:0] inc;
    logic [31:0] mask;
    inc  = a + (32'd1 << sz);
    mask = ((32'(ln) + 32'd1) << sz) - 32'd1;
    if (bt == 2'b00) return a;
    if (bt == 2'b10 && (ln == 4'd1 || ln == 4'd3 || ln == 4'd7 || ln == 4'd15))
      return (a & ~mask) | (inc & mask);
    return inc;
  endfunction

  function automatic logic beat_err(input logic [31:0] a, input logic [2:0] sz);
    return ((a >> (MEM_AW + 2)) != 32'd0) || (sz > 3'd2);
  endfunction

  assign nxt_addr = step_addr(addr_q, size_q, len_q, burst_q);

  // Read port: first beat comes from the request itself, later beats from the stepped address.
  always_comb begin
    rd_addr = nxt_addr;
    rd_size = size_q;
    if (state_q == IDLE) begin
      rd_addr = s_araddr;
      rd_size = s_arsize;
    end
  end

  assign rd_err  = beat_err(rd_addr, rd_size);
  assign rd_word = rd_err ? 32'd0 : mem_q[rd_addr[MEM_AW+1:2]];

  always_comb begin
    state_d    = state_q;
    grant_wr_d = grant_wr_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    err_any_d  = err_any_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rid_d      = rid_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    mem_we     = 1'b0;
    s_arready  = 1'b0;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    case (state_q)
      IDLE: begin
        s_arready = s_arvalid & (~s_awvalid | grant_wr_q);
        s_awready = s_awvalid & (~s_arvalid | ~grant_wr_q);
        if (s_awready) begin
          id_d       = s_awid;
          addr_d     = s_awaddr;
          len_d      = s_awlen;
          size_d     = s_awsize;
          burst_d    = s_awburst;
          cnt_d      = 5'd0;
          err_any_d  = 1'b0;
          grant_wr_d = 1'b1;
          state_d    = WDATA;
        end else if (s_arready) begin
          id_d       = s_arid;
          addr_d     = s_araddr;
          len_d      = s_arlen;
          size_d     = s_arsize;
          burst_d    = s_arburst;
          cnt_d      = 5'd0;
          err_any_d  = 1'b0;
          grant_wr_d = 1'b0;
          rvalid_d   = 1'b1;
          rid_d      = s_arid;
          rdata_d    = rd_word;
          rresp_d    = rd_err ? 2'b10 : 2'b00;
          rlast_d    = (s_arlen == 4'd0);
          state_d    = RBURST;
        end
      end
      RBURST: begin
        if (s_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            addr_d  = nxt_addr;
            cnt_d   = cnt_q + 5'd1;
            rdata_d = rd_word;
            rresp_d = rd_err ? 2'b10 : 2'b00;
            rlast_d = ((cnt_q + 5'd1) == {1'b0, len_q});
          end
        end
      end
      WDATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          if (cnt_q > {1'b0, len_q} || beat_err(addr_q, size_q)) err_any_d = 1'b1;
          else mem_we = 1'b1;
          if (s_wlast && cnt_q != {1'b0, len_q}) err_any_d = 1'b1;
          addr_d = nxt_addr;
          // Saturate so overrun beats keep registering as beyond len.
          if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
          if (s_wlast) begin
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_any_d ? 2'b10 : 2'b00;
            state_d  = WRESP;
          end
        end
      end
      WRESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_wr_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= 32'd0;
      len_q      <= 4'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      cnt_q      <= 5'd0;
      err_any_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= 2'd0;
      rid_q      <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'd0;
      bid_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_wr_q <= grant_wr_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      err_any_q  <= err_any_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rid_q      <= rid_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
    end
  end

  // Memory survives reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_wstrb[i]) mem_q[addr_q[MEM_AW+1:2]][8*i +: 8] <= s_wdata[8*i +: 8];
      end
    end
  end

  assign s_rvalid = rvalid_q;
  assign s_rlast  = rlast_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign s_rid    = rid_q;
  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_bid    = bid_q;

  logic unused_ok;
  assign unused_ok = ^{s_arlock, s_arcache, s_arprot, s_awlock, s_awcache, s_awprot, s_wid};
endmodule

// File: tb/tb_axi3_sram_responder.sv
// Directed bench for axi3_sram_responder: bursts, wrap, sub-word writes, arbitration, errors, reset.
module tb_axi3_sram_responder;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [3:0]  s_arid = '0, s_awid = '0, s_wid = '0, s_rid, s_bid;
  logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0, s_rdata;
  logic [3:0]  s_arlen = '0, s_awlen = '0, s_wstrb = '0;
  logic [2:0]  s_arsize = '0, s_awsize = '0;
  logic [1:0]  s_arburst = '0, s_awburst = '0, s_rresp, s_bresp;
  logic        s_arvalid = 1'b0, s_awvalid = 1'b0, s_wvalid = 1'b0, s_wlast = 1'b0;
  logic        s_rready = 1'b0, s_bready = 1'b0;
  logic        s_arready, s_awready, s_wready, s_rvalid, s_rlast, s_bvalid;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdat [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [3:0]  rids [16];

  axi3_sram_responder #(.MEM_AW(10), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(2'b00), .s_arcache(4'h0), .s_arprot(3'b000),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(2'b00), .s_awcache(4'h0), .s_awprot(3'b000),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (s_awready !== 1'b1 && n < 50);
    check("aw_accept", 32'(s_awready), 32'd1);
    @(posedge aclk); #1 s_awvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [3:0] len, input logic [31:0] d0, input logic [3:0] strb);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      s_wdata = d0 + 32'(i); s_wstrb = strb; s_wlast = (i == int'(len)); s_wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (s_wready !== 1'b1 && n < 50);
      check("w_accept", 32'(s_wready), 32'd1);
      @(posedge aclk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("b_latency", 32'(s_bvalid), 32'd1);
  endtask

  task automatic b_hs(input string tag, input logic [3:0] eid, input logic [1:0] eresp);
    int n;
    s_bready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (s_bvalid !== 1'b1 && n < 50);
    check({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
    check({tag, "_bid"}, 32'(s_bid), 32'(eid));
    check({tag, "_bresp"}, 32'(s_bresp), 32'(eresp));
    @(posedge aclk); #1 s_bready = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (s_arready !== 1'b1 && n < 50);
    check("ar_accept", 32'(s_arready), 32'd1);
    @(posedge aclk); #1 s_arvalid = 1'b0;
    check("r_latency", 32'(s_rvalid), 32'd1);
  endtask

  task automatic r_beats(input logic [3:0] len);
    int n;
    s_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      do begin @(negedge aclk); n++; end while (s_rvalid !== 1'b1 && n < 50);
      check("r_valid", 32'(s_rvalid), 32'd1);
      rdat[i] = s_rdata; rrsp[i] = s_rresp; rlst[i] = s_rlast; rids[i] = s_rid;
      @(posedge aclk); #1;
    end
    s_rready = 1'b0;
    check("r_end", 32'(s_rvalid), 32'd0);
  endtask

  task automatic read_one(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    ar_hs(4'd0, addr, 4'd0, 3'd2, 2'b01);
    r_beats(4'd0);
    check(tag, rdat[0], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_rvalid", 32'(s_rvalid), 32'd0);
    check("rst_bvalid", 32'(s_bvalid), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_wready", 32'(s_wready), 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;

    // Arbitration straight out of reset: write wins, then a repeated conflict goes to the read.
    s_arid = 4'd3; s_araddr = 32'h200; s_arlen = 4'd0; s_arsize = 3'd2; s_arburst = 2'b01;
    s_awid = 4'd1; s_awaddr = 32'h200; s_awlen = 4'd0; s_awsize = 3'd2; s_awburst = 2'b01;
    s_arvalid = 1'b1; s_awvalid = 1'b1;
    @(negedge aclk);
    check("t5_first_awready", 32'(s_awready), 32'd1);
    check("t5_first_arready", 32'(s_arready), 32'd0);
    @(posedge aclk); #1 s_awvalid = 1'b0;
    @(negedge aclk);
    check("t5_busy_arready", 32'(s_arready), 32'd0);
    @(posedge aclk); #1;
    w_beats(4'd0, 32'h1234_5678, 4'hF);
    s_awid = 4'd2; s_awaddr = 32'h204; s_awvalid = 1'b1;
    @(negedge aclk);
    check("t5_wresp_awready", 32'(s_awready), 32'd0);
    @(posedge aclk); #1;
    b_hs("t5_w1", 4'd1, 2'b00);
    @(negedge aclk);
    check("t5_second_arready", 32'(s_arready), 32'd1);
    check("t5_second_awready", 32'(s_awready), 32'd0);
    @(posedge aclk); #1 s_arvalid = 1'b0;
    check("t5_r_latency", 32'(s_rvalid), 32'd1);
    r_beats(4'd0);
    check("t5_rdata_after_b", rdat[0], 32'h1234_5678);
    check("t5_rid", 32'(rids[0]), 32'd3);
    aw_hs(4'd2, 32'h204, 4'd0, 3'd2, 2'b01);
    w_beats(4'd0, 32'h0BAD_BEEF, 4'hF);
    b_hs("t5_w2", 4'd2, 2'b00);

    // INCR write then read back.
    aw_hs(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
    w_beats(4'd3, 32'hA0, 4'hF);
    b_hs("t2", 4'd5, 2'b00);
    ar_hs(4'd7, 32'h100, 4'd3, 3'd2, 2'b01);
    r_beats(4'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_rdata%0d", i), rdat[i], 32'hA0 + 32'(i));
      check($sformatf("t2_rlast%0d", i), 32'(rlst[i]), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("t2_rid%0d", i), 32'(rids[i]), 32'd7);
      check($sformatf("t2_rresp%0d", i), 32'(rrsp[i]), 32'd0);
    end

    // WRAP read around a 16-byte block.
    ar_hs(4'd1, 32'h108, 4'd3, 3'd2, 2'b10);
    r_beats(4'd3);
    check("t3_rdata0", rdat[0], 32'hA2);
    check("t3_rdata1", rdat[1], 32'hA3);
    check("t3_rdata2", rdat[2], 32'hA0);
    check("t3_rdata3", rdat[3], 32'hA1);
    check("t3_rresp3", 32'(rrsp[3]), 32'd0);
    check("t3_rlast3", 32'(rlst[3]), 32'd1);

    // FIXED read repeats one word.
    ar_hs(4'd2, 32'h104, 4'd2, 3'd2, 2'b00);
    r_beats(4'd2);
    check("fx_rdata0", rdat[0], 32'hA1);
    check("fx_rdata2", rdat[2], 32'hA1);
    check("fx_rlast1", 32'(rlst[1]), 32'd0);
    check("fx_rlast2", 32'(rlst[2]), 32'd1);

    // Byte write merges into existing word.
    aw_hs(4'd4, 32'h101, 4'd0, 3'd0, 2'b01);
    w_beats(4'd0, 32'h0000_5500, 4'b0010);
    b_hs("t4", 4'd4, 2'b00);
    read_one("t4_merged", 32'h100, 32'h0000_55A0);

    // Reset during an outstanding read beat.
    ar_hs(4'd6, 32'h108, 4'd0, 3'd2, 2'b01);
    check("t1_pre_rlast", 32'(s_rlast), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("t1_rvalid_drop", 32'(s_rvalid), 32'd0);
    check("t1_rlast_drop", 32'(s_rlast), 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    check("t1_arready_idle", 32'(s_arready), 32'd0);
    s_arvalid = 1'b1;
    #1 check("t1_arready_follow", 32'(s_arready), 32'd1);
    s_arvalid = 1'b0;
    #1 check("t1_arready_drop", 32'(s_arready), 32'd0);
    @(posedge aclk); #1;
    read_one("t1_mem_kept", 32'h10C, 32'hA3);

    // Out-of-range read and write report SLVERR and leave memory alone.
    aw_hs(4'd0, 32'h0, 4'd0, 3'd2, 2'b01);
    w_beats(4'd0, 32'hCAFE_F00D, 4'hF);
    b_hs("t6_w0", 4'd0, 2'b00);
    ar_hs(4'd9, 32'h0001_0000, 4'd1, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t6_hold_rvalid", 32'(s_rvalid), 32'd1);
      check("t6_hold_rdata", s_rdata, 32'd0);
      check("t6_hold_rresp", 32'(s_rresp), 32'd2);
      check("t6_hold_rlast", 32'(s_rlast), 32'd0);
    end
    @(posedge aclk); #1;
    r_beats(4'd1);
    check("t6_rdata0", rdat[0], 32'd0);
    check("t6_rresp0", 32'(rrsp[0]), 32'd2);
    check("t6_rdata1", rdat[1], 32'd0);
    check("t6_rresp1", 32'(rrsp[1]), 32'd2);
    check("t6_rlast1", 32'(rlst[1]), 32'd1);
    check("t6_rid", 32'(rids[1]), 32'd9);
    aw_hs(4'd8, 32'h0001_0000, 4'd0, 3'd2, 2'b01);
    w_beats(4'd0, 32'hFFFF_FFFF, 4'hF);
    b_hs("t6_werr", 4'd8, 2'b10);
    read_one("t6_mem_unchanged", 32'h0, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
